// File: rtl/hamming_pkg.sv
// Shared definitions for the serial Hamming(7,4) receive path: widths, receiver
// FSM state type and the syndrome function.
package hamming_pkg;

   localparam int unsigned CODE_W = 7;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned SYN_W  = 3;

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK, OUT} rx_state_t;

   // code[i] holds code position i+1 (b1 at code[0], b7 at code[6]).
   // The syndrome value equals the position of a single flipped bit.
   function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] code);
      logic [SYN_W-1:0] s;
      s[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
      s[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
      s[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
      return s;
   endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational Hamming(7,4) checker: syndrome of a received codeword plus the
// data nibble after flipping the bit the syndrome points at.
import hamming_pkg::*;

module hamming74_syndrome (
   input  logic [CODE_W-1:0] code,
   output logic [SYN_W-1:0]  syn,
   output logic [DATA_W-1:0] data
);

   logic [CODE_W-1:0] fixed;

   // Syndrome, single-bit correction and data extraction (d1 = b3 is the MSB).
   always_comb begin
      syn   = syndrome(code);
      fixed = code;
      for (int i = 0; i < int'(CODE_W); i++) begin
         if (syn == SYN_W'(i + 1)) begin
            fixed[i] = ~code[i];
         end
      end
      data = {fixed[2], fixed[4], fixed[5], fixed[6]};
   end

endmodule

// File: rtl/hamming_rx_decoder.sv
// Serial Hamming(7,4) receiver feeding the Display block.
// Bits arrive b1 first, one per cycle with rx_valid=1; the decoded nibble, ready
// and err appear two edges after the edge that accepts b7.
// Build option: define HAMMING_CORRECT_EN to correct single-bit errors; without it
// an errored frame only raises err and leaves a..d and ready untouched.
import hamming_pkg::*;

module hamming_rx_decoder #(
   parameter int unsigned IDLE_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic rx_bit,
   input  logic rx_valid,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic ready,
   output logic err
);

   localparam int unsigned IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

   rx_state_t state_q, state_d;

   logic [CODE_W-1:0] code_q, code_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [SYN_W-1:0]  syn_q, syn_d;
   logic [DATA_W-1:0] fix_q, fix_d;
   logic [DATA_W-1:0] abcd_q, abcd_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;

   logic [SYN_W-1:0]  chk_syn;
   logic [DATA_W-1:0] chk_data;
   logic              accept;
   logic              last_bit;
   logic              timeout;

   hamming74_syndrome u_syndrome (
      .code (code_q),
      .syn  (chk_syn),
      .data (chk_data)
   );

   // Bits are only taken while collecting a frame; CHECK and OUT ignore rx_valid.
   assign accept   = rx_valid && ((state_q == IDLE) || (state_q == SHIFT));
   assign last_bit = accept && (state_q == SHIFT) && (bit_cnt_q == 3'd6);
   assign timeout  = (state_q == SHIFT) && !rx_valid &&
                     (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = SHIFT;
         SHIFT: begin
            if (last_bit)     state_d = CHECK;
            else if (timeout) state_d = IDLE;
         end
         CHECK:   state_d = OUT;
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values driven by the current state.
   always_comb begin
      code_d     = code_q;
      bit_cnt_d  = 3'd0;
      idle_cnt_d = '0;
      syn_d      = syn_q;
      fix_d      = fix_q;
      abcd_d     = abcd_q;
      ready_d    = ready_q;
      err_d      = err_q;

      if (accept) begin
         code_d = {rx_bit, code_q[CODE_W-1:1]};
      end

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               bit_cnt_d = 3'd1;
               ready_d   = 1'b0;
            end
         end
         SHIFT: begin
            if (accept) begin
               bit_cnt_d = last_bit ? 3'd0 : bit_cnt_q + 3'd1;
            end else if (!timeout) begin
               bit_cnt_d  = bit_cnt_q;
               idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
         end
         CHECK: begin
            syn_d = chk_syn;
            fix_d = chk_data;
         end
         OUT: begin
`ifdef HAMMING_CORRECT_EN
            abcd_d  = fix_q;
            ready_d = 1'b1;
            err_d   = (syn_q != '0);
`else
            if (syn_q == '0) begin
               abcd_d  = fix_q;
               ready_d = 1'b1;
               err_d   = 1'b0;
            end else begin
               err_d   = 1'b1;
            end
`endif
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         code_q     <= '0;
         bit_cnt_q  <= 3'd0;
         idle_cnt_q <= '0;
         syn_q      <= '0;
         fix_q      <= '0;
         abcd_q     <= '0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         code_q     <= code_d;
         bit_cnt_q  <= bit_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         syn_q      <= syn_d;
         fix_q      <= fix_d;
         abcd_q     <= abcd_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
      end
   end

   assign {a, b, c, d} = abcd_q;
   assign ready        = ready_q;
   assign err          = err_q;

endmodule

// File: tb/tb_hamming_rx_decoder.sv
// Scoreboard bench for hamming_rx_decoder: the driver pushes timed expected output
// snapshots from a position-arithmetic Hamming model; a negedge monitor applies
// them when due and compares the outputs every cycle.
module tb_hamming_rx_decoder;

   logic clk;
   logic reset;
   logic rx_bit;
   logic rx_valid;
   logic a, b, c, d, ready, err;

   hamming_rx_decoder #(
      .IDLE_TIMEOUT (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_bit   (rx_bit),
      .rx_valid (rx_valid),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .ready    (ready),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [5:0] v;    // {a,b,c,d,ready,err}
   } ev_t;

   ev_t        evq[$];
   logic [5:0] exp_v = '0;
   logic [5:0] m_v   = '0;
   int         cyc    = 0;
   int         checks = 0;
   int         errors = 0;
   bit         mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: apply due expectations, then compare the visible outputs.
   always @(negedge clk) begin
      if (mon_en) begin
         while (evq.size() > 0 && evq[0].cyc <= cyc) begin
            exp_v = evq[0].v;
            void'(evq.pop_front());
         end
         checks++;
         if ({a, b, c, d, ready, err} !== exp_v) begin
            errors++;
            if (errors <= 30)
               $display("FAIL outputs cyc=%0d got abcd=%b ready=%b err=%b, expected abcd=%b ready=%b err=%b",
                        cyc, {a, b, c, d}, ready, err, exp_v[5:2], exp_v[1], exp_v[0]);
         end
      end
   end

   // Reference: the syndrome is the XOR of the positions of all set bits.
   function automatic logic [5:0] ref_decode(input logic [7:1] cw, input logic [3:0] prev);
      int         s = 0;
      logic [7:1] w = cw;
      for (int p = 1; p <= 7; p++) if (cw[p]) s = s ^ p;
`ifdef HAMMING_CORRECT_EN
      if (s != 0) w[s] = ~w[s];
      return {w[3], w[5], w[6], w[7], 1'b1, (s != 0)};
`else
      if (s != 0) return {prev, 1'b0, 1'b1};
      return {w[3], w[5], w[6], w[7], 1'b1, 1'b0};
`endif
   endfunction

   function automatic logic [7:1] encode(input logic [3:0] dat);
      logic [7:1] cw = '0;
      int         s  = 0;
      cw[3] = dat[3]; cw[5] = dat[2]; cw[6] = dat[1]; cw[7] = dat[0];
      for (int p = 1; p <= 7; p++) if (cw[p]) s = s ^ p;
      cw[1] = s[0]; cw[2] = s[1]; cw[4] = s[2];
      return cw;
   endfunction

   // First listed bit is b1.
   function automatic logic [7:1] from_seq(input logic [6:0] sq);
      logic [7:1] cw;
      for (int i = 1; i <= 7; i++) cw[i] = sq[7-i];
      return cw;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic bv);
      rx_valid = 1'b1;
      rx_bit   = bv;
      step(1);
      rx_valid = 1'b0;
      rx_bit   = 1'($urandom_range(0, 1));
   endtask

   task automatic push(input int when);
      ev_t e;
      e.cyc = when;
      e.v   = m_v;
      evq.push_back(e);
   endtask

   // Sends bits b1..bk; gap<0 picks random gaps of 0..3, bit long_at gets a 15-cycle gap.
   task automatic send_bits(input logic [7:1] cw, input int k, input int gap, input int long_at);
      for (int i = 1; i <= k; i++) begin
         if (i > 1) begin
            int g;
            g = (i == long_at) ? 15 : ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
            step(g);
         end
         drive_bit(cw[i]);
         if (i == 1) begin
            m_v[1] = 1'b0;
            push(cyc);
         end
      end
   endtask

   task automatic send_frame(input logic [7:1] cw, input int gap, input int long_at);
      send_bits(cw, 7, gap, long_at);
      m_v = ref_decode(cw, m_v[5:2]);
      push(cyc + 2);
      // A bit offered while the frame is being checked must be ignored.
      rx_valid = 1'b1;
      rx_bit   = 1'($urandom_range(0, 1));
      step(1);
      rx_valid = 1'b0;
      step(1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      m_v   = '0;
      push(cyc);
      step(2);
      reset = 1'b1;
   endtask

   initial begin
      logic [7:1] cw;
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_bit   = 1'b0;
      #2 reset = 1'b0;
      #1 mon_en = 1'b1;
      step(3);
      reset = 1'b1;
      step(2);

      send_frame(from_seq(7'b1101001), 0, 0);  // clean 0001
      send_frame(from_seq(7'b1011010), 3, 0);  // clean 1010 with gaps
      send_frame(from_seq(7'b1101101), 0, 0);  // error in b5
      send_bits(from_seq(7'b1101001), 3, 0, 0); // partial frame, then timeout
      step(16);
      send_frame(from_seq(7'b1101001), 0, 0);
      send_bits(from_seq(7'b1011010), 4, 0, 0); // reset mid-frame
      do_reset();
      send_frame(from_seq(7'b1011010), 1, 0);
      send_frame(encode(4'b0110), 0, 0);        // back-to-back frames
      send_frame(encode(4'b1001), 0, 0);
      send_frame(encode(4'b1111), 0, 4);        // 15-idle gap stays in frame

      for (int n = 0; n < 60; n++) begin
         int mode;
         mode = int'($urandom_range(0, 9));
         cw   = encode(4'($urandom_range(0, 15)));
         if (mode == 0) begin
            send_bits(cw, int'($urandom_range(1, 6)), -1, 0);
            step(16);
         end else if (mode == 1) begin
            send_bits(cw, int'($urandom_range(1, 6)), -1, 0);
            do_reset();
         end else begin
            if ($urandom_range(0, 1) == 1) begin
               int p;
               p = int'($urandom_range(1, 7));
               cw[p] = ~cw[p];
            end
            send_frame(cw, -1, (mode == 2) ? int'($urandom_range(2, 7)) : 0);
         end
      end

      step(4);
      checks++;
      if (evq.size() != 0) begin
         errors++;
         $display("FAIL pending_events got %0d, expected 0", evq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
